// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t    : control FSM states (one state per trap cause so every
//                  output stays a pure function of state + instruction)
//   - alu_op_t   : ALU_operation encodings understood by the datapath ALU
//   - opcode / funct / COP0 rs field constants
//   - CP0 cause codes, PCSource / MemtoReg / mux select encodings
//   - funct_alu(): R-type funct -> ALU operation
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_INIT,
        S_IF,
        S_ID,
        S_EX_R,
        S_WB_R,
        S_EX_I,
        S_WB_I,
        S_LUI,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BR,
        S_JMP,
        S_JAL,
        S_JR,
        S_JALR,
        S_MFC0,
        S_MTC0,
        S_ERET,
        S_TRAP_INT,
        S_TRAP_SYS,
        S_TRAP_RI,
        S_TRAP_OV
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000
    } alu_op_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    // COP0 rs field and eret funct
    localparam logic [4:0] RS_MF   = 5'h00;
    localparam logic [4:0] RS_MT   = 5'h04;
    localparam logic [4:0] RS_CO   = 5'h10;
    localparam logic [5:0] FN_ERET = 6'h18;

    // CP0 cause codes
    localparam logic [4:0] CAUSE_INT = 5'd0;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_RI  = 5'd10;
    localparam logic [4:0] CAUSE_OV  = 5'd12;

    // PCSource encodings (the trap vector select is a top-level parameter)
    localparam logic [2:0] PCS_ALU    = 3'b000;
    localparam logic [2:0] PCS_BRANCH = 3'b001;
    localparam logic [2:0] PCS_JUMP   = 3'b010;
    localparam logic [2:0] PCS_REG    = 3'b011;
    localparam logic [2:0] PCS_EPC    = 3'b101;

    // MemtoReg encodings
    localparam logic [2:0] MTR_ALU = 3'b000;
    localparam logic [2:0] MTR_MEM = 3'b001;
    localparam logic [2:0] MTR_LUI = 3'b010;
    localparam logic [2:0] MTR_PC  = 3'b011;
    localparam logic [2:0] MTR_CP0 = 3'b100;

    // RegDst / ALUSrcA / ALUSrcB encodings
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_RA  = 2'b10;
    localparam logic [1:0] SA_PC  = 2'b00;
    localparam logic [1:0] SA_RS  = 2'b01;
    localparam logic [1:0] SA_PCQ = 2'b11;
    localparam logic [1:0] SB_RT  = 2'b00;
    localparam logic [1:0] SB_4   = 2'b01;
    localparam logic [1:0] SB_IMM = 2'b10;
    localparam logic [1:0] SB_BR  = 2'b11;

    function automatic alu_op_t funct_alu(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_XOR:  op = ALU_XOR;
            FN_NOR:  op = ALU_NOR;
            FN_SLT:  op = ALU_SLT;
            FN_SLL:  op = ALU_SLL;
            FN_SRL:  op = ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_irq_sync.sv
// irq_sync: synchronises the asynchronous level int_req, detects its rising
// edge and holds a pending flag until the controller takes the interrupt.
//   clk, reset : system clock, synchronous active-high reset
//   int_req    : asynchronous external interrupt request (level)
//   clr        : clear pending (controller is in the interrupt trap state)
//   pending    : an interrupt edge has been seen and not yet serviced
// STAGES (1..3) sets the synchroniser depth.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic int_req,
    input  logic clr,
    output logic pending
);

    logic [STAGES-1:0] sync;
    logic              sync_q;
    logic              rise;

    assign rise = sync[STAGES-1] & ~sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            sync_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync[0] <= int_req;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            sync_q <= sync[STAGES-1];
            // A fresh edge wins over a simultaneous clear so it is not lost.
            if (rise) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS control FSM for the data_path.
// Sequences fetch/decode/execute/memory/writeback plus trap and eret, owns
// the interrupt-enable flag (ie) and interrupt acceptance.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   Inst_in[31:0]               : latched instruction (datapath Inst_R)
//   zero, overflow              : ALU flags of the current cycle
//   MIO_ready                   : bus transfer complete
//   int_req                     : asynchronous interrupt request (level)
//   MemRead, MemWrite           : bus strobes
//   IorD, IRWrite, RegWrite, data2Mem, RegDst, ALUSrcA, ALUSrcB,
//   MemtoReg, PCSource, PCWrite, PCWriteCond, Beq, Signext,
//   ALU_operation               : datapath controls
//   WriteEPC, WriteCause, WriteCp0, WriteIen, InTcause, Int_en : CP0 controls
// Build option: CTRL_IRQ_EN enables the int_req path (synchroniser, pending
// latch, interrupt check on IF entry). Without it int_req is ignored.
import ctrl_pkg::*;

module multi_cycle_ctrl #(
    parameter int unsigned IRQ_SYNC_STAGES = 2,
    parameter logic [2:0]  TRAP_VECTOR_SEL = 3'b100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        int_req,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        data2Mem,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  MemtoReg,
    output logic [2:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Beq,
    output logic        Signext,
    output logic [3:0]  ALU_operation,
    output logic        WriteEPC,
    output logic        WriteCause,
    output logic        WriteCp0,
    output logic        WriteIen,
    output logic [4:0]  InTcause,
    output logic        Int_en
);

    state_t      state, state_next;
    logic        ie;
    logic        irq_pending;
    logic        is_trap;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic        unused_bits;

    assign opcode = Inst_in[31:26];
    assign rs     = Inst_in[25:21];
    assign funct  = Inst_in[5:0];

    // Branch resolution (zero) is done by the datapath via PCWriteCond/Beq.
    assign unused_bits = ^{Inst_in[20:6], zero};

`ifdef CTRL_IRQ_EN
    irq_sync #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .int_req (int_req),
        .clr     (state == S_TRAP_INT),
        .pending (irq_pending)
    );
`else
    localparam int unsigned unused_stages = IRQ_SYNC_STAGES;
    logic unused_irq;
    assign unused_irq  = int_req;
    assign irq_pending = 1'b0;
`endif

    assign is_trap = (state == S_TRAP_INT) || (state == S_TRAP_SYS) ||
                     (state == S_TRAP_RI)  || (state == S_TRAP_OV);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            ie    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_ERET) begin
                ie <= 1'b1;
            end else if (is_trap) begin
                ie <= 1'b0;
            end
        end
    end

    always_comb begin
        state_t fetch_next;

        // Entering IF from a completed instruction is where an enabled,
        // pending interrupt is taken instead of fetching.
        fetch_next = (ie && irq_pending) ? S_TRAP_INT : S_IF;

        state_next    = state;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        data2Mem      = 1'b0;
        RegDst        = '0;
        ALUSrcA       = '0;
        ALUSrcB       = '0;
        MemtoReg      = '0;
        PCSource      = '0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Beq           = 1'b0;
        Signext       = 1'b0;
        ALU_operation = '0;
        WriteEPC      = 1'b0;
        WriteCause    = 1'b0;
        WriteCp0      = 1'b0;
        WriteIen      = 1'b0;
        InTcause      = '0;
        Int_en        = 1'b0;

        case (state)
            S_INIT: state_next = S_IF;

            S_IF: begin
                IorD          = 1'b1;
                MemRead       = 1'b1;
                IRWrite       = 1'b1;
                ALUSrcA       = SA_PC;
                ALUSrcB       = SB_4;
                ALU_operation = ALU_ADD;
                PCSource      = PCS_ALU;
                PCWrite       = 1'b1;
                if (MIO_ready) state_next = S_ID;
            end

            S_ID: begin
                ALUSrcA       = SA_PC;
                ALUSrcB       = SB_BR;
                ALU_operation = ALU_ADD;
                Signext       = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                            FN_SLT, FN_SLL, FN_SRL: state_next = S_EX_R;
                            FN_JR:      state_next = S_JR;
                            FN_JALR:    state_next = S_JALR;
                            FN_SYSCALL: state_next = S_TRAP_SYS;
                            default:    state_next = S_TRAP_RI;
                        endcase
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_next = S_EX_I;
                    OP_LUI:          state_next = S_LUI;
                    OP_LW, OP_SW:    state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_next = S_BR;
                    OP_J:            state_next = S_JMP;
                    OP_JAL:          state_next = S_JAL;
                    OP_COP0: begin
                        if (rs == RS_MF)                           state_next = S_MFC0;
                        else if (rs == RS_MT)                      state_next = S_MTC0;
                        else if (rs == RS_CO && funct == FN_ERET)  state_next = S_ERET;
                        else                                       state_next = S_TRAP_RI;
                    end
                    default: state_next = S_TRAP_RI;
                endcase
            end

            // ALU inputs and operation stay applied through writeback so the
            // ALU result is stable for the whole instruction.
            S_EX_R, S_WB_R: begin
                ALUSrcA       = SA_RS;
                ALUSrcB       = SB_RT;
                ALU_operation = funct_alu(funct);
                if (state == S_EX_R) begin
                    if (overflow && (funct == FN_ADD || funct == FN_SUB))
                        state_next = S_TRAP_OV;
                    else
                        state_next = S_WB_R;
                end else begin
                    RegDst     = RD_RD;
                    MemtoReg   = MTR_ALU;
                    RegWrite   = 1'b1;
                    state_next = fetch_next;
                end
            end

            S_EX_I, S_WB_I: begin
                ALUSrcA = SA_RS;
                ALUSrcB = SB_IMM;
                Signext = (opcode == OP_ADDI) || (opcode == OP_SLTI);
                case (opcode)
                    OP_ANDI: ALU_operation = ALU_AND;
                    OP_ORI:  ALU_operation = ALU_OR;
                    OP_XORI: ALU_operation = ALU_XOR;
                    OP_SLTI: ALU_operation = ALU_SLT;
                    default: ALU_operation = ALU_ADD;
                endcase
                if (state == S_EX_I) begin
                    if (overflow && opcode == OP_ADDI) state_next = S_TRAP_OV;
                    else                               state_next = S_WB_I;
                end else begin
                    RegDst     = RD_RT;
                    MemtoReg   = MTR_ALU;
                    RegWrite   = 1'b1;
                    state_next = fetch_next;
                end
            end

            S_LUI: begin
                MemtoReg   = MTR_LUI;
                RegDst     = RD_RT;
                RegWrite   = 1'b1;
                state_next = fetch_next;
            end

            S_MEM_ADDR: begin
                ALUSrcA       = SA_RS;
                ALUSrcB       = SB_IMM;
                ALU_operation = ALU_ADD;
                Signext       = 1'b1;
                state_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                if (MIO_ready) state_next = S_MEM_WB;
            end

            S_MEM_WB: begin
                MemtoReg   = MTR_MEM;
                RegDst     = RD_RT;
                RegWrite   = 1'b1;
                state_next = fetch_next;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                if (MIO_ready) state_next = fetch_next;
            end

            S_BR: begin
                ALUSrcA       = SA_RS;
                ALUSrcB       = SB_RT;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = PCS_BRANCH;
                Beq           = (opcode == OP_BEQ);
                state_next    = fetch_next;
            end

            S_JMP: begin
                PCSource   = PCS_JUMP;
                PCWrite    = 1'b1;
                state_next = fetch_next;
            end

            S_JAL: begin
                RegDst     = RD_RA;
                MemtoReg   = MTR_PC;
                RegWrite   = 1'b1;
                PCSource   = PCS_JUMP;
                PCWrite    = 1'b1;
                state_next = fetch_next;
            end

            S_JR, S_JALR: begin
                ALUSrcA       = SA_RS;
                ALUSrcB       = SB_RT;
                ALU_operation = ALU_OR;
                PCSource      = PCS_REG;
                PCWrite       = 1'b1;
                if (state == S_JALR) begin
                    RegDst   = RD_RD;
                    MemtoReg = MTR_PC;
                    RegWrite = 1'b1;
                end
                state_next = fetch_next;
            end

            S_MFC0: begin
                MemtoReg   = MTR_CP0;
                RegDst     = RD_RT;
                RegWrite   = 1'b1;
                state_next = fetch_next;
            end

            S_MTC0: begin
                WriteCp0   = 1'b1;
                state_next = fetch_next;
            end

            // ie is still 0 here, so the instruction at EPC is always fetched.
            S_ERET: begin
                PCSource   = PCS_EPC;
                PCWrite    = 1'b1;
                WriteIen   = 1'b1;
                Int_en     = 1'b1;
                state_next = fetch_next;
            end

            S_TRAP_INT, S_TRAP_SYS, S_TRAP_RI, S_TRAP_OV: begin
                WriteEPC   = 1'b1;
                WriteCause = 1'b1;
                PCSource   = TRAP_VECTOR_SEL;
                PCWrite    = 1'b1;
                WriteIen   = 1'b1;
                Int_en     = 1'b0;
                if (state == S_TRAP_INT) begin
                    InTcause      = CAUSE_INT;
                    ALUSrcA       = SA_PCQ;
                    ALUSrcB       = SB_4;
                    ALU_operation = ALU_ADD;
                end else begin
                    case (state)
                        S_TRAP_SYS: InTcause = CAUSE_SYS;
                        S_TRAP_RI:  InTcause = CAUSE_RI;
                        default:    InTcause = CAUSE_OV;
                    endcase
                    ALUSrcA       = SA_PC;
                    ALUSrcB       = SB_4;
                    ALU_operation = ALU_SUB;
                end
                state_next = S_IF;
            end

            default: state_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl. Inputs change 1 ns after each
// rising edge; outputs are checked at that same point.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero, overflow, MIO_ready, int_req;
    logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, data2Mem;
    logic [1:0]  RegDst, ALUSrcA, ALUSrcB;
    logic [2:0]  MemtoReg, PCSource;
    logic        PCWrite, PCWriteCond, Beq, Signext;
    logic [3:0]  ALU_operation;
    logic        WriteEPC, WriteCause, WriteCp0, WriteIen;
    logic [4:0]  InTcause;
    logic        Int_en;
    logic [35:0] all_out;
    logic        taken;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_BEQ  = 32'h1021_0004; // beq  $1,$1,4
    localparam logic [31:0] I_BNE  = 32'h1421_0004; // bne  $1,$1,4
    localparam logic [31:0] I_ADDI = 32'h2022_0005; // addi $2,$1,5
    localparam logic [31:0] I_ERET = 32'h4200_0018; // eret
    localparam logic [31:0] I_BAD  = 32'hFC00_0000; // opcode 6'h3F
    localparam logic [31:0] I_SW   = 32'hAC22_0000; // sw   $2,0($1)
    localparam logic [31:0] I_LW   = 32'h8C22_0000; // lw   $2,0($1)
    localparam logic [31:0] I_LUI  = 32'h3C01_0001; // lui  $1,1

    multi_cycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .Inst_in       (Inst_in),
        .zero          (zero),
        .overflow      (overflow),
        .MIO_ready     (MIO_ready),
        .int_req       (int_req),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IorD          (IorD),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .data2Mem      (data2Mem),
        .RegDst        (RegDst),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .MemtoReg      (MemtoReg),
        .PCSource      (PCSource),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .Beq           (Beq),
        .Signext       (Signext),
        .ALU_operation (ALU_operation),
        .WriteEPC      (WriteEPC),
        .WriteCause    (WriteCause),
        .WriteCp0      (WriteCp0),
        .WriteIen      (WriteIen),
        .InTcause      (InTcause),
        .Int_en        (Int_en)
    );

    always #5 clk = ~clk;

    assign all_out = {MemRead, MemWrite, IorD, IRWrite, RegWrite, data2Mem,
                      RegDst, ALUSrcA, ALUSrcB, MemtoReg, PCSource,
                      PCWrite, PCWriteCond, Beq, Signext, ALU_operation,
                      WriteEPC, WriteCause, WriteCp0, WriteIen, InTcause, Int_en};

    // Datapath branch decision: PCWriteCond gated by zero (beq) or !zero (bne).
    assign taken = PCWriteCond & (Beq ? zero : ~zero);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called while in IF: present the instruction and complete the fetch.
    task automatic fetch(input logic [31:0] instr);
        Inst_in   = instr;
        MIO_ready = 1'b1;
        tick();
        MIO_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Inst_in = '0; zero = 1'b0; overflow = 1'b0;
        MIO_ready = 1'b0; int_req = 1'b0;
        tick(); tick();
        chk("reset_all_zero", all_out, 36'h0);
        reset = 1'b0;
        Inst_in = I_ADD;
        tick();

        // add with MIO_ready low for three IF cycles, high on the fourth
        for (int i = 0; i < 4; i++) begin
            chk("if_hold_memread", MemRead, 1);
            chk("if_hold_irwrite", IRWrite, 1);
            if (i == 3) MIO_ready = 1'b1;
            tick();
        end
        MIO_ready = 1'b0;
        chk("id_alusrcb", ALUSrcB, 2'b11);
        chk("id_memread", MemRead, 0);
        tick();
        chk("exr_alusrca", ALUSrcA, 2'b01);
        chk("exr_aluop", ALU_operation, 4'b0010);
        chk("exr_regwrite", RegWrite, 0);
        tick();
        chk("wbr_regdst", RegDst, 2'b01);
        chk("wbr_regwrite", RegWrite, 1);
        chk("wbr_aluop", ALU_operation, 4'b0010);
        tick();
        chk("add_back_if", IRWrite, 1);

        // beq $1,$1 taken, bne $1,$1 not taken
        zero = 1'b1;
        fetch(I_BEQ); tick();
        chk("beq_pcwc", PCWriteCond, 1);
        chk("beq_pcsrc", PCSource, 3'b001);
        chk("beq_flag", Beq, 1);
        chk("beq_aluop", ALU_operation, 4'b0110);
        chk("beq_taken", taken, 1);
        tick();
        fetch(I_BNE); tick();
        chk("bne_pcwc", PCWriteCond, 1);
        chk("bne_flag", Beq, 0);
        chk("bne_taken", taken, 0);
        tick();
        zero = 1'b0;

        // addi overflow -> TRAP(OV)
        fetch(I_ADDI); tick();
        chk("exi_alusrcb", ALUSrcB, 2'b10);
        chk("exi_signext", Signext, 1);
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        chk("ov_regwrite", RegWrite, 0);
        chk("ov_cause", InTcause, 5'd12);
        chk("ov_pcsrc", PCSource, 3'b100);
        chk("ov_inten", Int_en, 0);
        chk("ov_writeien", WriteIen, 1);
        chk("ov_writeepc", WriteEPC, 1);
        tick();
        chk("ov_back_if", IRWrite, 1);

        // reserved opcode -> TRAP(RI)
        fetch(I_BAD); tick();
        chk("ri_cause", InTcause, 5'd10);
        chk("ri_writecause", WriteCause, 1);
        tick();

        // sw held until MIO_ready
        fetch(I_SW); tick();
        chk("sw_addr_srca", ALUSrcA, 2'b01);
        chk("sw_addr_srcb", ALUSrcB, 2'b10);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_memwrite", MemWrite, 1);
            chk("sw_iord", IorD, 0);
            chk("sw_data2mem", data2Mem, 0);
            if (i == 2) MIO_ready = 1'b1;
            tick();
        end
        MIO_ready = 1'b0;
        chk("sw_done_memwrite", MemWrite, 0);
        chk("sw_done_if", IRWrite, 1);

        // interrupt edge while ie=0 stays pending; taken after eret
        int_req = 1'b1;
        tick(); tick(); tick();
        int_req = 1'b0;
        chk("irq_masked_if", MemRead, 1);
        fetch(I_ADD); tick(); tick(); tick();
        chk("irq_masked_no_trap", {IRWrite, WriteEPC}, 2'b10);
        fetch(I_ERET); tick();
        chk("eret_pcsrc", PCSource, 3'b101);
        chk("eret_ien", {WriteIen, Int_en, PCWrite}, 3'b111);
        tick();
        chk("eret_fetches", {IRWrite, WriteEPC}, 2'b10);
        fetch(I_LUI); tick();
        chk("lui_wb", {MemtoReg, RegWrite}, 4'b0101);
        tick();
`ifdef CTRL_IRQ_EN
        chk("int_writeepc", WriteEPC, 1);
        chk("int_cause", InTcause, 5'd0);
        chk("int_alusrca", ALUSrcA, 2'b11);
        chk("int_no_fetch", MemRead, 0);
        tick();
`else
        chk("noirq_fetch", {IRWrite, WriteEPC}, 2'b10);
`endif
        chk("after_int_if", MemRead, 1);

        // reset during MEM_RD
        fetch(I_LW); tick(); tick();
        chk("lw_memread", {MemRead, IorD}, 2'b10);
        tick();
        chk("lw_memread_held", MemRead, 1);
        reset = 1'b1;
        tick();
        chk("midop_reset_zero", all_out, 36'h0);
        reset = 1'b0;
        tick();
        chk("post_reset_if", {MemRead, IRWrite}, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
